// File: rtl/display_scanner_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_SHOW
    } state_t;

    // Wide enough for the largest supported digit count; sliced by users.
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot counter (cnt) and digit index (idx) pair for the display scanner.
module scan_timer #(
    parameter int DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD = 500,
    localparam int CW = $clog2(PRESCALE),
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clear,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] idx_next,
    output logic          slot_end,
    output logic          guard_end,
    output logic          frame_wrap
);

    localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] S_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DIGITS - 1);

    logic [CW-1:0] cnt;

    assign guard_end  = run && (cnt == G_LAST);
    assign slot_end   = run && (cnt == S_LAST);
    assign frame_wrap = slot_end && (idx == D_LAST);

    always_comb begin
        idx_next = idx;
        if (clear)
            idx_next = '0;
        else if (slot_end)
            idx_next = frame_wrap ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            idx <= idx_next;
            if (clear)
                cnt <= '0;
            else if (run)
                cnt <= slot_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed digit scanner with guard interval, leading-zero
// suppression and frame-aligned double buffering of the displayed value.
import display_scanner_pkg::*;

module display_scanner #(
    parameter int DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD = 500,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            bcdin,
    output logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    state_t state, state_nxt;

    logic [4*DIGITS-1:0] shadow, pending, shadow_nxt;
    logic                pend_valid, commit;
    logic                run, clear;
    logic [IW-1:0]       idx, idx_next;
    logic                slot_end, guard_end, frame_wrap;

    scan_timer #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .GUARD   (GUARD)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .idx       (idx),
        .idx_next  (idx_next),
        .slot_end  (slot_end),
        .guard_end (guard_end),
        .frame_wrap(frame_wrap)
    );

    assign clear      = !enable || (state == ST_IDLE);
    assign run        = !clear;
    assign commit     = pend_valid && (frame_wrap || state == ST_IDLE);
    assign shadow_nxt = commit ? pending : shadow;

    // Digit 0 is never zero-suppressed, so a value of 0 still shows "0".
    function automatic logic sup(input logic [4*DIGITS-1:0] v,
                                 input logic [IW-1:0] i,
                                 input logic lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (k >= int'(i) && v[4*k +: 4] != 4'd0)
                upper_zero = 1'b0;
        return !is_bcd(v[{i, 2'b00} +: 4]) || (lz && i != '0 && upper_zero);
    endfunction

    always_comb begin
        state_nxt = state;
        if (!enable)
            state_nxt = ST_IDLE;
        else begin
            unique case (state)
                ST_IDLE:  state_nxt = ST_GUARD;
                ST_GUARD: if (guard_end) state_nxt = ST_SHOW;
                ST_SHOW:  if (slot_end) state_nxt = ST_GUARD;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            an         <= ANODE_OFF[DIGITS-1:0];
            blank      <= 1'b1;
            bcdin      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_wrap;
            if (load) begin
                pending    <= value;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
            if (commit)
                shadow <= pending;
            // Outputs follow the state being entered, so they are registered.
            an    <= ANODE_OFF[DIGITS-1:0];
            blank <= 1'b1;
            bcdin <= '0;
            if (state_nxt != ST_IDLE)
                bcdin <= shadow_nxt[{idx_next, 2'b00} +: 4];
            if (state_nxt == ST_SHOW) begin
                an    <= ~(DIGITS'(1) << idx_next);
                blank <= sup(shadow_nxt, idx_next, lz_en);
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (4 digits, 8-cycle slots).
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst, enable, load, lz_en;
    logic [15:0] value;
    logic [3:0]  bcdin, an;
    logic        blank, frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    display_scanner #(
        .DIGITS  (4),
        .PRESCALE(8),
        .GUARD   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .lz_en     (lz_en),
        .bcdin     (bcdin),
        .blank     (blank),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk({tag, "_sync"}, 32'(seen), 32'd1);
    endtask

    // Starts on the first guard cycle of digit 0; ends on the next one.
    task automatic check_frame(input string tag, input logic [15:0] dig,
                               input logic [3:0] blk,
                               input int la = -1, input logic [15:0] lav = 0,
                               input int lb = -1, input logic [15:0] lbv = 0);
        for (int k = 0; k < 32; k++) begin
            int d;
            int p;
            logic [3:0] e_an;
            d = k / 8;
            p = k % 8;
            load = (k == la) || (k == lb);
            if (k == la) value = lav;
            else if (k == lb) value = lbv;
            chk($sformatf("%s_fd%0d", tag, k), 32'(frame_done), 32'(k == 0));
            if (p < 2) begin
                chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'hF);
                chk($sformatf("%s_bl%0d", tag, k), 32'(blank), 32'd1);
            end else begin
                e_an = 4'hF;
                e_an[d] = 1'b0;
                chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(e_an));
                chk($sformatf("%s_bl%0d", tag, k), 32'(blank), 32'(blk[d]));
                chk($sformatf("%s_bcd%0d", tag, k), 32'(bcdin),
                    32'(dig[4*d +: 4]));
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; lz_en = 1'b0; value = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_bcd", 32'(bcdin), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_an", 32'(an), 32'hF);
        chk("idle_blank", 32'(blank), 32'd1);
        chk("idle_bcd", 32'(bcdin), 32'd0);
        chk("idle_fd", 32'(frame_done), 32'd0);

        value = 16'h1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        wait_frame("scan");
        check_frame("scan", 16'h1234, 4'b0000);
        lz_en = 1'b1;
        check_frame("lz_load", 16'h1234, 4'b0000, 4, 16'h0050);
        check_frame("lz_0050", 16'h0050, 4'b1100, 31, 16'h0000);
        check_frame("wrap_load", 16'h0050, 4'b1100);
        check_frame("lz_zero", 16'h0000, 4'b1110);
        lz_en = 1'b0;
        check_frame("nolz", 16'h0000, 4'b0000, 12, 16'h9999);
        check_frame("buf_9999", 16'h9999, 4'b0000, 3, 16'h1111, 20, 16'h2222);
        check_frame("last_wins", 16'h2222, 4'b0000, 7, 16'hA000);
        check_frame("bad_nolz", 16'hA000, 4'b1000);
        lz_en = 1'b1;
        check_frame("bad_lz", 16'hA000, 4'b1000);

        repeat (20) @(negedge clk);
        chk("d2_an", 32'(an), 32'hB);
        chk("d2_blank", 32'(blank), 32'd0);
        chk("d2_bcd", 32'(bcdin), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_an", 32'(an), 32'hF);
        chk("drop_blank", 32'(blank), 32'd1);
        chk("drop_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("drop2_an", 32'(an), 32'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("re_g0_an", 32'(an), 32'hF);
        chk("re_g0_blank", 32'(blank), 32'd1);
        @(negedge clk);
        chk("re_g1_an", 32'(an), 32'hF);
        chk("re_g1_blank", 32'(blank), 32'd1);
        @(negedge clk);
        chk("re_show_an", 32'(an), 32'hE);
        chk("re_show_blank", 32'(blank), 32'd0);
        chk("re_show_bcd", 32'(bcdin), 32'd0);

        rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_blank", 32'(blank), 32'd1);
        chk("arst_bcd", 32'(bcdin), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_an", 32'(an), 32'hF);
        chk("post_blank", 32'(blank), 32'd1);
        chk("post_bcd", 32'(bcdin), 32'd0);
        chk("post_fd", 32'(frame_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
